lfsr_grid_seeder: RTL and testbench

Downstream consumer of the 64-bit LFSR (`lfsrx64`) output. It samples one or more consecutive LFSR words and ANDs them together, giving a programmable live-cell density. The result is presented as a 64-cell (8×8) initial grid to the next stage over a valid/ready handshake, together with its live-cell count. It guarantees a non-empty grid, retrying a bounded number of times before flagging an all-zero result.

---
 rtl/lfsr_grid_seeder.sv | 138 +++++++++++++
 tb/tb_lfsr_grid_seeder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_grid_seeder.sv
// Builds an 8x8 initial grid by ANDing 1..4 consecutive LFSR words, retrying
// a bounded number of times so the grid is non-empty unless retries run out.
module lfsr_grid_seeder #(
  parameter int WIDTH     = 64,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] lfsr_in,
  input  logic             start,
  input  logic [1:0]       density,
  output logic [WIDTH-1:0] grid_out,
  output logic [6:0]       live_count,
  output logic             grid_valid,
  input  logic             grid_ready,
  output logic             zero_grid,
  output logic             busy
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    HOLD
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] grid_reg, grid_next;
  logic [WIDTH-1:0] nxt;
  logic [1:0]       k_reg, k_next;
  logic [1:0]       cnt_reg, cnt_next;
  logic [RW-1:0]    retry_reg, retry_next;
  logic [6:0]       live_reg, live_next;
  logic             zero_reg, zero_next;
  logic             valid_reg;
  logic             busy_reg;

  function automatic logic [6:0] popcount(input logic [WIDTH-1:0] v);
    logic [6:0] s;
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s = s + {6'd0, v[i]};
    end
    return s;
  endfunction

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    grid_next  = grid_reg;
    k_next     = k_reg;
    cnt_next   = cnt_reg;
    retry_next = retry_reg;
    live_next  = live_reg;
    zero_next  = zero_reg;
    nxt        = acc_reg & lfsr_in;

    case (state_reg)
      IDLE: begin
        if (start) begin
          k_next     = density;
          acc_next   = '1;
          cnt_next   = '0;
          retry_next = '0;
          state_next = SAMPLE;
        end
      end

      SAMPLE: begin
        cnt_next = cnt_reg + 2'd1;
        // cnt counts from 0, so cnt == k_reg marks the k-th (last) word
        if (cnt_reg == k_reg) begin
          if (nxt != '0) begin
            grid_next  = nxt;
            live_next  = popcount(nxt);
            zero_next  = 1'b0;
            state_next = HOLD;
          end else if (int'(retry_reg) < MAX_RETRY) begin
            retry_next = retry_reg + RW'(1);
            acc_next   = '1;
            cnt_next   = '0;
          end else begin
            grid_next  = '0;
            live_next  = '0;
            zero_next  = 1'b1;
            state_next = HOLD;
          end
        end else begin
          acc_next = nxt;
        end
      end

      HOLD: begin
        if (grid_ready) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // valid/busy are registered from the next state so no input reaches an output combinationally
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      grid_reg  <= '0;
      k_reg     <= '0;
      cnt_reg   <= '0;
      retry_reg <= '0;
      live_reg  <= '0;
      zero_reg  <= 1'b0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      grid_reg  <= grid_next;
      k_reg     <= k_next;
      cnt_reg   <= cnt_next;
      retry_reg <= retry_next;
      live_reg  <= live_next;
      zero_reg  <= zero_next;
      valid_reg <= (state_next == HOLD);
      busy_reg  <= (state_next != IDLE);
    end
  end

  assign grid_out   = grid_reg;
  assign live_count = live_reg;
  assign zero_grid  = zero_reg;
  assign grid_valid = valid_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_lfsr_grid_seeder.sv
// Bench for lfsr_grid_seeder: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_lfsr_grid_seeder;
  localparam int WIDTH     = 64;
  localparam int MAX_RETRY = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] lfsr_in = '0;
  logic             start = 1'b0;
  logic [1:0]       density = 2'd0;
  logic             grid_ready = 1'b0;
  logic [WIDTH-1:0] grid_out;
  logic [6:0]       live_count;
  logic             grid_valid;
  logic             zero_grid;
  logic             busy;

  int checks = 0;
  int errors = 0;

  lfsr_grid_seeder #(.WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY)) dut (
    .clk       (clk),
    .reset     (reset),
    .lfsr_in   (lfsr_in),
    .start     (start),
    .density   (density),
    .grid_out  (grid_out),
    .live_count(live_count),
    .grid_valid(grid_valid),
    .grid_ready(grid_ready),
    .zero_grid (zero_grid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a grid request collects words in groups of k, ANDs each group,
  // and gives up after MAX_RETRY+1 empty groups.
  bit               m_busy = 0;
  bit               m_valid = 0;
  bit               m_zero = 0;
  logic [63:0]      m_grid = '0;
  logic [6:0]       m_count = '0;
  logic [63:0]      m_and;
  int               m_k = 1;
  int               m_attempt = 0;
  logic [63:0]      m_words[$];

  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_busy = 0; m_valid = 0; m_zero = 0; m_grid = '0; m_count = '0;
        m_attempt = 0; m_words.delete();
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1;
          m_k = int'(density) + 1;
          m_attempt = 0;
          m_words.delete();
        end
      end else if (!m_valid) begin
        m_words.push_back(lfsr_in);
        if (m_words.size() == m_k) begin
          m_and = '1;
          foreach (m_words[i]) m_and = m_and & m_words[i];
          m_words.delete();
          if (m_and != 64'd0) begin
            m_grid = m_and; m_count = 7'($countones(m_and)); m_zero = 0; m_valid = 1;
          end else if (m_attempt == MAX_RETRY) begin
            m_grid = '0; m_count = '0; m_zero = 1; m_valid = 1;
          end else begin
            m_attempt++;
          end
        end
      end else if (grid_ready) begin
        $display("TXN grid=%h count=%0d zero=%0b", m_grid, m_count, m_zero);
        m_valid = 0;
        m_busy = 0;
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      cmp("grid_out",   grid_out,   m_grid);
      cmp("live_count", {57'd0, live_count}, {57'd0, m_count});
      cmp("grid_valid", {63'd0, grid_valid}, {63'd0, m_valid});
      cmp("zero_grid",  {63'd0, zero_grid},  {63'd0, m_zero});
      cmp("busy",       {63'd0, busy},       {63'd0, m_busy});
    end
  end

  initial begin
    // reset with start held high
    reset = 1'b0; start = 1'b1;
    repeat (2) @(negedge clk);
    cmp("rst_busy", {63'd0, busy}, 64'd0);
    cmp("rst_valid", {63'd0, grid_valid}, 64'd0);
    cmp("rst_grid", grid_out, 64'd0);
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    cmp("idle_busy", {63'd0, busy}, 64'd0);

    // density 0: single word, valid one cycle after the start edge
    density = 2'd0; lfsr_in = 64'h0040_4040_0006_0400; grid_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cmp("d0_busy", {63'd0, busy}, 64'd1);
    cmp("d0_notvalid", {63'd0, grid_valid}, 64'd0);
    @(negedge clk);
    cmp("d0_valid", {63'd0, grid_valid}, 64'd1);
    cmp("d0_grid", grid_out, 64'h0040_4040_0006_0400);
    cmp("d0_count", {57'd0, live_count}, 64'd6);
    @(negedge clk);
    cmp("d0_onecycle", {63'd0, grid_valid}, 64'd0);

    // density 2: three words
    density = 2'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    lfsr_in = 64'hFFFF_0000_FFFF_0000; @(negedge clk);
    cmp("d2_early", {63'd0, grid_valid}, 64'd0);
    lfsr_in = 64'hF0F0_F0F0_F0F0_F0F0; @(negedge clk);
    lfsr_in = 64'hFF00_FF00_FF00_FF00; @(negedge clk);
    cmp("d2_valid", {63'd0, grid_valid}, 64'd1);
    cmp("d2_grid", grid_out, 64'hF000_0000_F000_0000);
    cmp("d2_count", {57'd0, live_count}, 64'd8);
    @(negedge clk);

    // backpressure with toggling inputs
    grid_ready = 1'b0; density = 2'd0; lfsr_in = 64'h0123_4567_89AB_CDEF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      lfsr_in = {$urandom, $urandom}; start = ~start; density = 2'(i);
      @(negedge clk);
      cmp("bp_valid", {63'd0, grid_valid}, 64'd1);
      cmp("bp_grid", grid_out, 64'h0123_4567_89AB_CDEF);
      cmp("bp_count", {57'd0, live_count}, 64'd32);
    end
    // start during the accepting edge is ignored; held one more edge it is taken
    grid_ready = 1'b1; start = 1'b1; density = 2'd0;
    @(negedge clk);
    cmp("acc_valid", {63'd0, grid_valid}, 64'd0);
    cmp("acc_busy", {63'd0, busy}, 64'd0);
    @(negedge clk); start = 1'b0;
    cmp("restart_busy", {63'd0, busy}, 64'd1);
    lfsr_in = 64'h8000_0000_0000_0001; @(negedge clk);
    cmp("restart_count", {57'd0, live_count}, 64'd2);
    @(negedge clk);

    // all-zero: four attempts of two words, then zero_grid
    density = 2'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      lfsr_in = (i % 2 == 1) ? 64'h5555_5555_5555_5555 : 64'hAAAA_AAAA_AAAA_AAAA;
      @(negedge clk);
      if (i == 6) cmp("z_early", {63'd0, grid_valid}, 64'd0);
    end
    cmp("z_valid", {63'd0, grid_valid}, 64'd1);
    cmp("z_zero", {63'd0, zero_grid}, 64'd1);
    cmp("z_grid", grid_out, 64'd0);
    cmp("z_count", {57'd0, live_count}, 64'd0);
    @(negedge clk);

    // third attempt succeeds with all ones
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i >= 4) lfsr_in = '1;
      else lfsr_in = (i % 2 == 1) ? 64'h5555_5555_5555_5555 : 64'hAAAA_AAAA_AAAA_AAAA;
      @(negedge clk);
    end
    cmp("r3_valid", {63'd0, grid_valid}, 64'd1);
    cmp("r3_grid", grid_out, 64'hFFFF_FFFF_FFFF_FFFF);
    cmp("r3_count", {57'd0, live_count}, 64'd64);
    cmp("r3_zero", {63'd0, zero_grid}, 64'd0);
    @(negedge clk);

    // reset at the second SAMPLE cycle, then a fresh k=4 grid
    density = 2'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    lfsr_in = '1; @(negedge clk);
    reset = 1'b0; @(negedge clk);
    cmp("mr_busy", {63'd0, busy}, 64'd0);
    cmp("mr_valid", {63'd0, grid_valid}, 64'd0);
    cmp("mr_grid", grid_out, 64'd0);
    cmp("mr_count", {57'd0, live_count}, 64'd0);
    reset = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    lfsr_in = 64'hFFFF_FFFF_FFFF_FFFF; @(negedge clk);
    lfsr_in = 64'hFFFF_FFFF_0000_FFFF; @(negedge clk);
    lfsr_in = 64'h0F0F_FFFF_0000_FFFF; @(negedge clk);
    cmp("k4_early", {63'd0, grid_valid}, 64'd0);
    lfsr_in = 64'hFFFF_00FF_0000_00FF; @(negedge clk);
    cmp("k4_valid", {63'd0, grid_valid}, 64'd1);
    cmp("k4_grid", grid_out, 64'h0F0F_00FF_0000_00FF);
    cmp("k4_count", {57'd0, live_count}, 64'd24);
    @(negedge clk);

    // free-running mixed traffic, checked by the model only
    for (int i = 0; i < 150; i++) begin
      lfsr_in = {$urandom, $urandom} | {$urandom, $urandom};
      start = 1'($urandom_range(0, 1));
      density = 2'($urandom_range(0, 3));
      grid_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
